pcie_frame_dma_sched: RTL

PCIE_FRAME_DMA_SCHED -- requirements
Module: pcie_frame_dma_sched

---
 rtl/pcie_frame_dma_sched_if.sv | 45 ++++
 rtl/pcie_frame_dma_sched.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pcie_frame_dma_sched_if.sv
// FIFO read port and DMA burst port of the frame DMA scheduler.
// The master modport is the scheduler side; slave is the FIFO/DMA-engine side.
interface pcie_frame_dma_sched_if #(
    parameter int unsigned DATA_W = 128
);
    logic              fifo_rd_en;
    logic              fifo_rd_vld;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              dma_req;
    logic [31:0]       dma_addr;
    logic [7:0]        dma_len;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_data;
    logic              dma_valid;
    logic              dma_ready;
    logic              dma_last;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_vld,
        input  fifo_rd_data,
        output dma_req,
        output dma_addr,
        output dma_len,
        input  dma_ack,
        output dma_data,
        output dma_valid,
        input  dma_ready,
        output dma_last
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_vld,
        output fifo_rd_data,
        input  dma_req,
        input  dma_addr,
        input  dma_len,
        output dma_ack,
        input  dma_data,
        input  dma_valid,
        output dma_ready,
        input  dma_last
    );
endinterface

// File: rtl/pcie_frame_dma_sched.sv
// Frame DMA scheduler: splits a frame of FRAME_WORDS words into bursts of at most
// BURST_LEN words, requests each burst, then streams FIFO words as burst beats.
module pcie_frame_dma_sched #(
    parameter int unsigned DATA_W         = 128,
    parameter int unsigned BURST_LEN      = 16,
    parameter int unsigned FRAME_WORDS    = 259200,
    parameter int unsigned BYTES_PER_WORD = 16
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst_n,
    input  logic                   enable,
    input  logic                   frame_start,
    input  logic [31:0]            base_addr,
    pcie_frame_dma_sched_if.master bus,
    output logic                   frame_done,
    output logic                   busy
);
    localparam int unsigned WL_W = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {StIdle, StReq, StData, StDone} state_e;

    state_e          state_q, state_d;
    logic            armed_q, armed_d;
    logic            pending_q, pending_d;
    logic [31:0]     pend_addr_q, pend_addr_d;
    logic [31:0]     cur_addr_q, cur_addr_d;
    logic [31:0]     dma_addr_q, dma_addr_d;
    logic [7:0]      dma_len_q, dma_len_d;
    logic [7:0]      beat_q, beat_d;
    logic [WL_W-1:0] words_left_q, words_left_d;

    logic              beat_acc;
    logic              beat_last;
    logic [7:0]        next_len;
    logic              load_en;
    logic [31:0]       load_addr;
    logic [DATA_W-1:0] data_mux;

    // Beat acceptance and burst sizing.
    always_comb begin
        beat_acc  = (state_q == StData) && bus.fifo_rd_vld && bus.dma_ready;
        beat_last = (beat_q == dma_len_q - 8'd1);
        if (32'(words_left_q) > BURST_LEN) begin
            next_len = 8'(BURST_LEN);
        end else begin
            next_len = 8'(words_left_q);
        end
    end

    // Next-state logic for the burst FSM and frame bookkeeping.
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        pending_d    = pending_q;
        pend_addr_d  = pend_addr_q;
        cur_addr_d   = cur_addr_q;
        dma_addr_d   = dma_addr_q;
        dma_len_d    = dma_len_q;
        beat_d       = beat_q;
        words_left_d = words_left_q;
        load_en      = 1'b0;
        load_addr    = base_addr;

        unique case (state_q)
            StIdle: begin
                // A new frame takes priority; launching now would use the old address.
                if (frame_start) begin
                    load_en = 1'b1;
                end else if (enable && armed_q && (words_left_q != '0) && bus.fifo_rd_vld) begin
                    state_d    = StReq;
                    dma_len_d  = next_len;
                    dma_addr_d = cur_addr_q;
                end
            end
            StReq: begin
                if (frame_start) begin
                    pending_d   = 1'b1;
                    pend_addr_d = base_addr;
                end
                if (bus.dma_ack) begin
                    state_d = StData;
                    beat_d  = '0;
                end
            end
            StData: begin
                if (frame_start) begin
                    pending_d   = 1'b1;
                    pend_addr_d = base_addr;
                end
                if (beat_acc) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_last) begin
                        cur_addr_d   = cur_addr_q + 32'(dma_len_q) * BYTES_PER_WORD;
                        words_left_d = words_left_q - WL_W'(dma_len_q);
                        if (words_left_q == WL_W'(dma_len_q)) begin
                            // Pending start survives DONE so frame_done still pulses.
                            state_d = StDone;
                        end else begin
                            state_d = StIdle;
                            if (pending_d) begin
                                load_en   = 1'b1;
                                load_addr = pend_addr_d;
                            end
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                armed_d = 1'b0;
                if (frame_start) begin
                    load_en = 1'b1;
                end else if (pending_q) begin
                    load_en   = 1'b1;
                    load_addr = pend_addr_q;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_en) begin
            cur_addr_d   = load_addr;
            words_left_d = WL_W'(FRAME_WORDS);
            armed_d      = 1'b1;
            pending_d    = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q      <= StIdle;
            armed_q      <= 1'b0;
            pending_q    <= 1'b0;
            pend_addr_q  <= '0;
            cur_addr_q   <= '0;
            dma_addr_q   <= '0;
            dma_len_q    <= '0;
            beat_q       <= '0;
            words_left_q <= '0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            pending_q    <= pending_d;
            pend_addr_q  <= pend_addr_d;
            cur_addr_q   <= cur_addr_d;
            dma_addr_q   <= dma_addr_d;
            dma_len_q    <= dma_len_d;
            beat_q       <= beat_d;
            words_left_q <= words_left_d;
        end
    end

    // Outputs: the data path is a straight pass-through of the FIFO head in DATA.
    always_comb begin
        data_mux       = (state_q == StData) ? bus.fifo_rd_data : '0;
        bus.dma_data   = data_mux;
        bus.dma_req    = (state_q == StReq);
        bus.dma_valid  = (state_q == StData) && bus.fifo_rd_vld;
        bus.fifo_rd_en = beat_acc;
        bus.dma_last   = bus.dma_valid && beat_last;
        bus.dma_addr   = dma_addr_q;
        bus.dma_len    = dma_len_q;
        frame_done     = (state_q == StDone);
        busy           = (state_q != StIdle);
    end
endmodule
